ame_sobel_line_feeder: RTL and testbench
========================================

Name: ame_sobel_line_feeder

Overview:
- Front end for the AME Sobel filter.
- On a start request it reads six 6-pixel lines from the line-buffer RAM and streams them one per cycle to the filter's line input, with a one-cycle comp_init strobe on line 0.
- It then waits for the filter's comp_done, captures the 4x4 result block, and hands it downstream over a valid/ready handshake.
- One instance serves both filter directions; dir_i selects the vertical-memory bank (horizontal filter) or the horizontal-memory bank (vertical filter).

Parameters:
LINE_DATA_BITS, 7, bits per pixel on a line
COMP_DATA_BITS, 8, bits per Sobel result element
ADDR_BITS, 6, line-buffer RAM line-address width (excluding bank bit)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  start request; sampled only in IDLE
dir_i  in  1  0 = horizontal filter (vertical memory bank), 1 = vertical filter (horizontal memory bank); latched at start
base_addr_i  in  ADDR_BITS  first line address; latched at start
busy_o  out  1  high whenever state is not IDLE
rd_en_o  out  1  RAM read enable
rd_addr_o  out  1+ADDR_BITS  {bank, line address}
rd_data_i  in  6*LINE_DATA_BITS  RAM read data, valid one cycle after rd_en_o
comp_init_o  out  1  filter init strobe
line_data_o  out  [5:0][LINE_DATA_BITS-1:0]  line to filter
comp_done_i  in  1  filter result valid
comp_data_i  in  [3:0][3:0][COMP_DATA_BITS-1:0]  filter result
res_valid_o  out  1  result available
res_ready_i  in  1  downstream accepts
res_data_o  out  [3:0][3:0][COMP_DATA_BITS-1:0]  captured result
res_dir_o  out  1  dir of captured result

Behaviour:
- Reset (async, rst_n_i=0):
  - State IDLE; counters 0.
  - All outputs 0, including res_data_o, line_data_o and rd_addr_o.
- States:
  - IDLE -> READ on start_i=1; latch dir_i and base_addr_i. Call this cycle T.
  - READ lasts 6 cycles, T+1..T+6.
    - rd_en_o=1, rd_addr_o={dir, base+k}, k=0..5.
    - Address add is modulo 2^ADDR_BITS; wrap is legal, no carry into the bank bit.
    - READ -> WAIT after k=5.
  - Data path:
    - A one-cycle-delayed read-valid flag registers rd_data_i into line_data_o.
    - Line k is driven on cycle T+3+k (T+3..T+8).
    - comp_init_o=1 on T+3 only, coincident with line 0.
    - line_data_o holds its last value when not loading.
  - WAIT: entered at T+7. The last line still emits at T+8 through the pipeline, so WAIT must not block the data path.
    - On comp_done_i=1 (accepted only once all 6 lines have been emitted, i.e. from T+8 onward): capture comp_data_i into res_data_o and dir into res_dir_o, then go to OUT.
  - OUT: res_valid_o=1 and res_data_o stable until res_ready_i=1.
    - On handshake (valid & ready): res_valid_o drops next cycle; -> IDLE.
- Fixed latency: start to comp_init_o = 3 cycles.
- Boundary rules:
  - start_i while busy_o=1: ignored, no queuing.
  - start_i in the same cycle as the OUT handshake: ignored; state is still OUT. A new start is accepted the cycle after busy_o falls.
  - comp_done_i outside WAIT, or before all 6 lines are out: ignored.
  - comp_done_i held high for several cycles: only the first sample is captured.
  - res_ready_i high while res_valid_o=0: no effect.
  - res_ready_i tied high: OUT lasts exactly one cycle.
  - Reset mid-operation: immediate return to IDLE. rd_en_o, comp_init_o and res_valid_o drop asynchronously.
- Next start after an IDLE return: full 6-line sequence; no state is carried over.

Decomposition:
- Package ame_sobel_pkg:
  - typedef enum {IDLE, READ, WAIT, OUT} for the feeder state.
  - Constants SOBEL_LINE_NUM=6 and SOBEL_OUT_DIM=4.
  - Packed typedefs for the line type and the result type, parameterised by the bit widths as localparams.
- Sub-module ame_sobel_line_fetch: read counter, address generation, read-valid delay and line register.
- The top level holds the FSM, result capture and the output handshake.

Test Plan:
- Single block: start at T with base=10, dir=0; RAM line n = {6{n[6:0]}}.
  - Expect rd_addr 10..15 on T+1..T+6 and comp_init only at T+3.
  - Expect line_data_o = lines 10..15 on T+3..T+8.
  - Filter model asserts done at T+12 with element (r,c)=r*4+c; res_valid at T+13 with that data.
- Wrap: base=62, ADDR_BITS=6, dir=1.
  - Expect rd_addr bank bit 1 throughout and line addresses 62,63,0,1,2,3.
- Backpressure: hold res_ready=0 for 20 cycles.
  - res_valid stays 1 and res_data stays unchanged; busy stays 1.
  - A start pulse during this window produces no rd_en.
  - Release ready: one-cycle handshake, then busy=0 next cycle.
- Early or spurious done: pulse comp_done_i at T+5 and again at T+10 with a different pattern.
  - The T+5 pulse is ignored; only the T+10 pattern is captured.
- Reset mid-READ: drop rst_n_i at T+4.
  - All outputs are 0 immediately.
  - After release, start at base=0 runs a clean 6-line sequence with comp_init at +3.
- Back-to-back: res_ready tied 1; eight blocks started as soon as busy=0.
  - Each yields exactly 6 reads, one comp_init and one res_valid pulse, in order.

Source files
------------

// File: rtl/ame_sobel_pkg.sv
// Shared constants and types for the AME Sobel line feeder.
package ame_sobel_pkg;
  localparam int SOBEL_LINE_BITS = 7;
  localparam int SOBEL_COMP_BITS = 8;
  localparam int SOBEL_ADDR_BITS = 6;
  localparam int SOBEL_LINE_NUM  = 6;
  localparam int SOBEL_OUT_DIM   = 4;

  typedef logic [SOBEL_LINE_NUM-1:0][SOBEL_LINE_BITS-1:0] sobel_line_t;
  typedef logic [SOBEL_OUT_DIM-1:0][SOBEL_OUT_DIM-1:0][SOBEL_COMP_BITS-1:0] sobel_res_t;

  typedef enum logic [1:0] {IDLE, READ, WAIT, OUT} feeder_state_e;
endpackage

// File: rtl/ame_sobel_line_fetch.sv
// Six-line RAM read sequencer with the line register that feeds the filter.
module ame_sobel_line_fetch import ame_sobel_pkg::*; #(
  parameter int LINE_DATA_BITS = SOBEL_LINE_BITS,
  parameter int ADDR_BITS      = SOBEL_ADDR_BITS
) (
  input  logic                                         clk_i,
  input  logic                                         rst_n_i,
  input  logic                                         start_i,
  input  logic                                         dir_i,
  input  logic [ADDR_BITS-1:0]                         base_addr_i,
  output logic                                         rd_en_o,
  output logic [ADDR_BITS:0]                           rd_addr_o,
  input  logic [SOBEL_LINE_NUM*LINE_DATA_BITS-1:0]     rd_data_i,
  output logic [SOBEL_LINE_NUM-1:0][LINE_DATA_BITS-1:0] line_data_o,
  output logic                                         comp_init_o,
  output logic                                         last_read_o,
  output logic                                         lines_done_o
);
  localparam int CW = $clog2(SOBEL_LINE_NUM);

  logic                 rd_en_q, bank_q;
  logic [CW-1:0]        cnt_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 rd_vld_q, first_q, last_q, init_q, done_q;
  logic [SOBEL_LINE_NUM-1:0][LINE_DATA_BITS-1:0] line_q;
  logic                 last_read;

  assign last_read = rd_en_q && (cnt_q == CW'(SOBEL_LINE_NUM-1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_en_q  <= 1'b0;
      bank_q   <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      rd_vld_q <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      init_q   <= 1'b0;
      done_q   <= 1'b0;
      line_q   <= '0;
    end else begin
      if (start_i) begin
        rd_en_q <= 1'b1;
        cnt_q   <= '0;
        bank_q  <= dir_i;
        addr_q  <= base_addr_i;
      end else if (rd_en_q) begin
        rd_en_q <= !last_read;
        if (!last_read) begin
          cnt_q  <= cnt_q + 1'b1;
          // line address wraps inside the bank; the bank bit is never touched
          addr_q <= addr_q + 1'b1;
        end
      end
      rd_vld_q <= rd_en_q;
      first_q  <= rd_en_q && (cnt_q == '0);
      last_q   <= last_read;
      init_q   <= first_q;
      done_q   <= last_q;
      if (rd_vld_q) line_q <= rd_data_i;
    end
  end

  assign rd_en_o      = rd_en_q;
  assign rd_addr_o    = {bank_q, addr_q};
  assign line_data_o  = line_q;
  assign comp_init_o  = init_q;
  assign last_read_o  = last_read;
  assign lines_done_o = done_q;
endmodule

// File: rtl/ame_sobel_line_feeder.sv
// Sobel front end: streams six RAM lines to the filter, captures the 4x4 result
// and holds it for a valid/ready consumer.
module ame_sobel_line_feeder import ame_sobel_pkg::*; #(
  parameter int LINE_DATA_BITS = SOBEL_LINE_BITS,
  parameter int COMP_DATA_BITS = SOBEL_COMP_BITS,
  parameter int ADDR_BITS      = SOBEL_ADDR_BITS
) (
  input  logic                                          clk_i,
  input  logic                                          rst_n_i,
  input  logic                                          start_i,
  input  logic                                          dir_i,
  input  logic [ADDR_BITS-1:0]                          base_addr_i,
  output logic                                          busy_o,
  output logic                                          rd_en_o,
  output logic [ADDR_BITS:0]                            rd_addr_o,
  input  logic [SOBEL_LINE_NUM*LINE_DATA_BITS-1:0]      rd_data_i,
  output logic                                          comp_init_o,
  output logic [SOBEL_LINE_NUM-1:0][LINE_DATA_BITS-1:0] line_data_o,
  input  logic                                          comp_done_i,
  input  logic [SOBEL_OUT_DIM-1:0][SOBEL_OUT_DIM-1:0][COMP_DATA_BITS-1:0] comp_data_i,
  output logic                                          res_valid_o,
  input  logic                                          res_ready_i,
  output logic [SOBEL_OUT_DIM-1:0][SOBEL_OUT_DIM-1:0][COMP_DATA_BITS-1:0] res_data_o,
  output logic                                          res_dir_o
);
  feeder_state_e state_q, state_d;
  logic dir_q, lines_out_q, res_dir_q;
  logic [SOBEL_OUT_DIM-1:0][SOBEL_OUT_DIM-1:0][COMP_DATA_BITS-1:0] res_q;
  logic start_fire, last_read, lines_done, done_ok;

  assign start_fire = (state_q == IDLE) && start_i;
  // the last line leaves the register while already in WAIT, so accept from that cycle on
  assign done_ok    = (state_q == WAIT) && comp_done_i && (lines_out_q || lines_done);

  ame_sobel_line_fetch #(
    .LINE_DATA_BITS (LINE_DATA_BITS),
    .ADDR_BITS      (ADDR_BITS)
  ) u_fetch (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .start_i      (start_fire),
    .dir_i        (dir_i),
    .base_addr_i  (base_addr_i),
    .rd_en_o      (rd_en_o),
    .rd_addr_o    (rd_addr_o),
    .rd_data_i    (rd_data_i),
    .line_data_o  (line_data_o),
    .comp_init_o  (comp_init_o),
    .last_read_o  (last_read),
    .lines_done_o (lines_done)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i)     state_d = READ;
      READ:    if (last_read)   state_d = WAIT;
      WAIT:    if (done_ok)     state_d = OUT;
      OUT:     if (res_ready_i) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      lines_out_q <= 1'b0;
      res_q       <= '0;
      res_dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_fire) begin
        dir_q       <= dir_i;
        lines_out_q <= 1'b0;
      end else if (lines_done) begin
        lines_out_q <= 1'b1;
      end
      if (done_ok) begin
        res_q     <= comp_data_i;
        res_dir_q <= dir_q;
      end
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign res_valid_o = (state_q == OUT);
  assign res_data_o  = res_q;
  assign res_dir_o   = res_dir_q;
endmodule

// File: tb/tb_ame_sobel_line_feeder.sv
// Scoreboard bench for ame_sobel_line_feeder: stimulus pushes timed expectations,
// a negedge monitor pops and compares them.
module tb_ame_sobel_line_feeder;
  import ame_sobel_pkg::*;
  localparam int LB = 7;
  localparam int AB = 6;

  typedef struct { int cyc; logic [AB:0] addr; } addr_exp_t;
  typedef struct { int cyc; logic [6*LB-1:0] data; } line_exp_t;
  typedef struct { int cyc; sobel_res_t data; logic dir; } res_exp_t;

  logic clk_i = 1'b0, rst_n_i = 1'b0, start_i = 1'b0, dir_i = 1'b0;
  logic [AB-1:0] base_addr_i = '0;
  logic busy_o, rd_en_o, comp_init_o, res_valid_o, res_dir_o;
  logic [AB:0] rd_addr_o;
  logic [6*LB-1:0] rd_data_i = '0;
  sobel_line_t line_data_o;
  logic comp_done_i = 1'b0, res_ready_i = 1'b0;
  sobel_res_t comp_data_i = '0, res_data_o;

  logic [6*LB-1:0] mem [0:127];
  addr_exp_t addr_q[$];
  line_exp_t line_q[$];
  int        init_q[$];
  res_exp_t  res_q[$];

  int vectors = 0, miscompares = 0, cyc = 0, rdy_mode = 1;

  ame_sobel_line_feeder dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .dir_i(dir_i),
    .base_addr_i(base_addr_i), .busy_o(busy_o), .rd_en_o(rd_en_o),
    .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i), .comp_init_o(comp_init_o),
    .line_data_o(line_data_o), .comp_done_i(comp_done_i), .comp_data_i(comp_data_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
    .res_dir_o(res_dir_o)
  );

  initial forever #5 clk_i = ~clk_i;
  initial forever begin @(posedge clk_i); cyc++; end
  initial begin #500000; $display("FAIL watchdog expired at cycle %0d", cyc); $fatal(1); end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic sobel_res_t rnd_res();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step(); @(posedge clk_i); #1; endtask
  task automatic to_cyc(input int c); while (cyc < c) step(); endtask

  task automatic wait_idle();
    int n = 0;
    do begin step(); n++; end while (busy_o && n < 300);
    chk("idle_reached", 128'(busy_o), 128'(0));
  endtask

  // line k of a block lives at (base+k) mod 64 inside the selected bank
  task automatic push_reads(input int t, input logic [AB-1:0] base, input logic d);
    logic [AB-1:0] la;
    for (int k = 0; k < 6; k++) begin
      la = AB'((int'(base) + k) % 64);
      addr_q.push_back('{t + 1 + k, {d, la}});
      line_q.push_back('{t + 3 + k, mem[{d, la}]});
    end
    init_q.push_back(t + 3);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  128'(busy_o), 128'(0));
    chk({tag, "_rden"},  128'(rd_en_o), 128'(0));
    chk({tag, "_addr"},  128'(rd_addr_o), 128'(0));
    chk({tag, "_init"},  128'(comp_init_o), 128'(0));
    chk({tag, "_line"},  128'(line_data_o), 128'(0));
    chk({tag, "_valid"}, 128'(res_valid_o), 128'(0));
    chk({tag, "_data"},  res_data_o, 128'(0));
    chk({tag, "_dir"},   128'(res_dir_o), 128'(0));
  endtask

  task automatic run_block(input logic [AB-1:0] base, input logic d, input int dly,
                           input int hold, input bit hold_start, input sobel_res_t pat0);
    int t;
    wait_idle();
    start_i = 1'b1; dir_i = d; base_addr_i = base; t = cyc;
    push_reads(t, base, d);
    step();
    if (!hold_start) begin
      start_i = 1'b0; dir_i = 1'($urandom); base_addr_i = AB'($urandom);
    end
    to_cyc(t + 5);
    comp_done_i = 1'b1; comp_data_i = rnd_res();
    step();
    comp_done_i = 1'b0; comp_data_i = rnd_res();
    to_cyc(t + dly);
    for (int h = 0; h < hold; h++) begin
      comp_done_i = 1'b1;
      comp_data_i = (h == 0) ? pat0 : rnd_res();
      if (h == 0) res_q.push_back('{t + dly + 1, pat0, d});
      step();
    end
    comp_done_i = 1'b0;
  endtask

  initial begin : ram_model
    logic en; logic [AB:0] a;
    forever begin
      @(negedge clk_i); en = rd_en_o; a = rd_addr_o;
      @(posedge clk_i); #1;
      rd_data_i = en ? mem[a] : (6*LB)'({$urandom, $urandom});
    end
  end

  initial forever begin
    @(posedge clk_i); #1;
    if (rdy_mode == 0) res_ready_i = 1'($urandom_range(0, 1));
    else if (rdy_mode == 1) res_ready_i = 1'b1;
  end

  initial begin : monitor
    bit e;
    forever begin
      @(negedge clk_i);
      e = addr_q.size() > 0 && addr_q[0].cyc <= cyc;
      chk("rd_en", 128'(rd_en_o), 128'(e));
      if (e) begin chk("rd_addr", 128'(rd_addr_o), 128'(addr_q[0].addr)); void'(addr_q.pop_front()); end
      e = init_q.size() > 0 && init_q[0] <= cyc;
      chk("comp_init", 128'(comp_init_o), 128'(e));
      if (e) void'(init_q.pop_front());
      if (line_q.size() > 0 && line_q[0].cyc <= cyc) begin
        chk("line_data", 128'(line_data_o), 128'(line_q[0].data));
        void'(line_q.pop_front());
      end
      e = res_q.size() > 0 && res_q[0].cyc <= cyc;
      chk("res_valid", 128'(res_valid_o), 128'(e));
      if (e) begin
        chk("res_data", res_data_o, res_q[0].data);
        chk("res_dir", 128'(res_dir_o), 128'(res_q[0].dir));
        if (res_ready_i) void'(res_q.pop_front());
      end
    end
  end

  initial begin : stim
    sobel_res_t pat;
    int t;
    for (int n = 0; n < 128; n++) mem[n] = {6{7'(n)}};
    #2; chk_all_zero("reset");
    repeat (3) step();
    rst_n_i = 1'b1;

    // single block: element (r,c) = r*4+c, done at T+12
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) pat[r][c] = 8'(r * 4 + c);
    rdy_mode = 1;
    run_block(6'd10, 1'b0, 12, 1, 1'b0, pat);
    // address wrap inside bank 1, done held two cycles
    run_block(6'd62, 1'b1, 10, 2, 1'b0, rnd_res());

    // backpressure with an ignored start inside the window
    rdy_mode = 2; res_ready_i = 1'b0;
    run_block(6'd33, 1'b0, 9, 1, 1'b0, rnd_res());
    for (int i = 0; i < 20; i++) begin
      step();
      start_i = (i == 5);
      chk("bp_busy", 128'(busy_o), 128'(1));
    end
    start_i = 1'b0;
    res_ready_i = 1'b1;
    step();
    chk("bp_busy_fall", 128'(busy_o), 128'(0));
    rdy_mode = 1;

    // reset mid-READ
    wait_idle();
    start_i = 1'b1; dir_i = 1'b0; base_addr_i = 6'd20; t = cyc;
    push_reads(t, 6'd20, 1'b0);
    step(); start_i = 1'b0;
    to_cyc(t + 4);
    rst_n_i = 1'b0;
    addr_q.delete(); line_q.delete(); init_q.delete(); res_q.delete();
    #1; chk_all_zero("midreset");
    step(); rst_n_i = 1'b1;
    run_block(6'd0, 1'($urandom), 11, 1, 1'b0, rnd_res());

    // back-to-back with ready tied high and start held high
    for (int b = 0; b < 8; b++)
      run_block(AB'($urandom), 1'($urandom), int'($urandom_range(8, 12)), 1, 1'b1, rnd_res());
    start_i = 1'b0;

    // randomized blocks, random ready, spurious done while idle
    for (int n = 0; n < 128; n++) mem[n] = (6*LB)'({$urandom, $urandom});
    rdy_mode = 0;
    for (int b = 0; b < 20; b++) begin
      wait_idle();
      comp_done_i = 1'b1; comp_data_i = rnd_res();
      step();
      comp_done_i = 1'b0;
      run_block(AB'($urandom), 1'($urandom), int'($urandom_range(8, 14)),
                int'($urandom_range(1, 3)), 1'b0, rnd_res());
    end

    wait_idle();
    repeat (5) step();
    chk("addr_q_drained", 128'(addr_q.size()), 128'(0));
    chk("line_q_drained", 128'(line_q.size()), 128'(0));
    chk("init_q_drained", 128'(init_q.size()), 128'(0));
    chk("res_q_drained",  128'(res_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
